// File: rtl/abc_vector_sweeper_pkg.sv
// Shared types and constants for the A/B/C exhaustive sweeper.
package abc_sweep_pkg;
  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;
endpackage

// File: rtl/abc_vector_sweeper_if.sv
// Control, stimulus and result bundle between the sweeper and its user.
interface abc_vector_sweeper_if
  import abc_sweep_pkg::*;
#(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               abort;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_VEC-1:0] expected;
  logic               q_in;
  logic               a;
  logic               b;
  logic               c;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] truth;
  logic [NUM_VEC-1:0] mismatch;
  logic               pass;
  logic               valid_o;

  modport master (
    output start, abort, dwell, expected, q_in,
    input  a, b, c, busy, done, truth, mismatch, pass, valid_o
  );

  modport slave (
    input  start, abort, dwell, expected, q_in,
    output a, b, c, busy, done, truth, mismatch, pass, valid_o
  );
endinterface

// File: rtl/abc_vector_sweeper_dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);
  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign expire = (r_cnt == '0);
endmodule

// File: rtl/abc_vector_sweeper.sv
// Drives A/B/C through 000..111 with a programmable hold, samples Q at the end
// of each hold and compares the measured truth table with the expected one.
module abc_vector_sweeper
  import abc_sweep_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  abc_vector_sweeper_if.slave sw
);
  state_t             r_state;
  state_t             r_state_next;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   r_abc;
  logic [DWELL_W-1:0] r_dwell_m1;
  logic [NUM_VEC-1:0] r_exp;
  logic [NUM_VEC-1:0] r_truth;
  logic [NUM_VEC-1:0] r_mismatch;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic               r_pass;

  logic               w_accept;
  logic               w_sample;
  logic               w_last;
  logic               w_expire;
  logic               w_load;
  logic [DWELL_W-1:0] w_start_m1;
  logic [DWELL_W-1:0] w_load_value;
  logic [NUM_VEC-1:0] w_truth_upd;

  // A dwell of zero behaves as one, so the reload value saturates at zero.
  assign w_start_m1   = (sw.dwell == '0) ? '0 : sw.dwell - DWELL_W'(1);
  assign w_load       = w_accept | (w_sample & ~w_last);
  assign w_load_value = w_accept ? w_start_m1 : r_dwell_m1;

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .value  (w_load_value),
    .expire (w_expire)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VEC; gi++) begin : g_truth_upd
      assign w_truth_upd[gi] = (r_vec == VEC_W'(gi)) ? sw.q_in : r_truth[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_last       = 1'b0;
    if (sw.abort) begin
      r_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (sw.start) begin
            w_accept     = 1'b1;
            r_state_next = DRIVE;
          end
        end
        DRIVE: begin
          if (w_expire) begin
            w_sample = 1'b1;
            if (r_vec == VEC_W'(NUM_VEC - 1)) begin
              w_last       = 1'b1;
              r_state_next = FINISH;
            end
          end
        end
        FINISH:  r_state_next = IDLE;
        default: r_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_abc      <= '0;
      r_dwell_m1 <= '0;
      r_exp      <= '0;
      r_truth    <= '0;
      r_mismatch <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sw.abort) begin
        // Partial truth bits stay visible for debug after a cancelled sweep.
        r_abc   <= '0;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_pass  <= 1'b0;
      end else if (w_accept) begin
        r_dwell_m1 <= w_start_m1;
        r_exp      <= sw.expected;
        r_truth    <= '0;
        r_valid    <= 1'b0;
        r_pass     <= 1'b0;
        r_vec      <= '0;
        r_abc      <= '0;
        r_busy     <= 1'b1;
      end else if (w_sample) begin
        r_truth <= w_truth_upd;
        if (w_last) begin
          r_abc      <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_valid    <= 1'b1;
          r_mismatch <= w_truth_upd ^ r_exp;
          r_pass     <= (w_truth_upd == r_exp);
        end else begin
          r_vec <= r_vec + VEC_W'(1);
          r_abc <= r_vec + VEC_W'(1);
        end
      end
    end
  end

  assign sw.a        = r_abc[2];
  assign sw.b        = r_abc[1];
  assign sw.c        = r_abc[0];
  assign sw.busy     = r_busy;
  assign sw.done     = r_done;
  assign sw.truth    = r_truth;
  assign sw.mismatch = r_mismatch;
  assign sw.pass     = r_pass;
  assign sw.valid_o  = r_valid;
endmodule

// File: tb/tb_abc_vector_sweeper.sv
// Self-checking bench: models the Q block and predicts every cycle of a sweep.
module tb_abc_vector_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   q_mode = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  abc_vector_sweeper_if #(.DWELL_W(8)) sw_if ();

  // Q block under test: mode 0 is (A&B)|C, mode 1 is A^B^C.
  assign sw_if.q_in = q_mode ? (sw_if.a ^ sw_if.b ^ sw_if.c)
                             : ((sw_if.a & sw_if.b) | sw_if.c);

  abc_vector_sweeper #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  function automatic logic model_q(input bit mode, input int k);
    logic a, b, c;
    a = k[2];
    b = k[1];
    c = k[0];
    return mode ? (a ^ b ^ c) : ((a & b) | c);
  endfunction

  function automatic logic [2:0] abc_now();
    return {sw_if.a, sw_if.b, sw_if.c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sw_if.start = 0; sw_if.abort = 0; sw_if.dwell = 0; sw_if.expected = 0;
    rst_n = 0;
    repeat (3) step();
    tests_run++;
    if ({abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o, sw_if.pass} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got abc/busy/done/valid/pass=%b required 0000000",
               {abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o, sw_if.pass});
    end
    tests_run++;
    if ({sw_if.truth, sw_if.mismatch} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_tables: got truth=%h mismatch=%h required 00 00",
               sw_if.truth, sw_if.mismatch);
    end
    rst_n = 1;
    step();
    $display("[TB] reset: outputs checked");
  endtask

  // Runs one full sweep starting from IDLE; returns observing cycle 8D+2.
  task automatic run_sweep(input int dw, input logic [7:0] exp_tab, input bit mode,
                           input bit spam, input string tag);
    int d, done_cnt;
    logic [7:0] m_truth, m_mm;
    d = (dw == 0) ? 1 : dw;
    m_truth = '0;
    for (int k = 0; k < 8; k++) m_truth[k] = model_q(mode, k);
    m_mm = m_truth ^ exp_tab;
    q_mode = mode;
    sw_if.dwell = 8'(dw);
    sw_if.expected = exp_tab;
    sw_if.start = 1;
    step();
    done_cnt = 0;
    for (int n = 1; n <= 8 * d + 2; n++) begin
      if (sw_if.done === 1'b1) done_cnt++;
      if (n <= 8 * d) begin
        tests_run++;
        if ({abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o} !== {3'((n - 1) / d), 3'b100}) begin
          tests_failed++;
          $display("FAIL %s_drive cyc%0d: got abc=%b busy=%b done=%b valid=%b required abc=%b busy=1 done=0 valid=0",
                   tag, n, abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o, 3'((n - 1) / d));
        end
      end else if (n == 8 * d + 1) begin
        tests_run++;
        if ({abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o} !== 6'b000011) begin
          tests_failed++;
          $display("FAIL %s_done_cycle cyc%0d: got abc=%b busy=%b done=%b valid=%b required 000 0 1 1",
                   tag, n, abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o);
        end
        tests_run++;
        if ({sw_if.truth, sw_if.mismatch, sw_if.pass} !== {m_truth, m_mm, m_mm == 8'h00}) begin
          tests_failed++;
          $display("FAIL %s_result: got truth=%h mismatch=%h pass=%b required truth=%h mismatch=%h pass=%b",
                   tag, sw_if.truth, sw_if.mismatch, sw_if.pass, m_truth, m_mm, m_mm == 8'h00);
        end
      end else begin
        tests_run++;
        if ({sw_if.done, sw_if.valid_o, sw_if.busy, sw_if.truth, sw_if.pass} !==
            {3'b010, m_truth, m_mm == 8'h00}) begin
          tests_failed++;
          $display("FAIL %s_hold cyc%0d: got done=%b valid=%b busy=%b truth=%h pass=%b required 0 1 0 %h %b",
                   tag, n, sw_if.done, sw_if.valid_o, sw_if.busy, sw_if.truth, sw_if.pass,
                   m_truth, m_mm == 8'h00);
        end
      end
      if (spam && n <= 8 * d + 1) begin
        sw_if.start = 1'($urandom_range(0, 1));
        sw_if.dwell = 8'($urandom);
        sw_if.expected = 8'($urandom);
      end else begin
        sw_if.start = 0;
      end
      if (n < 8 * d + 2) step();
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt);
    end
    $display("[TB] %s: dwell=%0d exp=%h truth=%h mismatch=%h pass=%b",
             tag, dw, exp_tab, sw_if.truth, sw_if.mismatch, sw_if.pass);
  endtask

  task automatic test_basic();
    run_sweep(4, 8'hEA, 1'b0, 1'b0, "basic_d4");
  endtask

  task automatic test_dwell_zero();
    run_sweep(0, 8'hEA, 1'b0, 1'b0, "dwell0");
  endtask

  task automatic test_xor_mismatch();
    run_sweep(2, 8'hEA, 1'b1, 1'b0, "xor");
  endtask

  task automatic test_start_spam();
    run_sweep(3, 8'hEA, 1'b0, 1'b1, "spam");
  endtask

  task automatic test_back_to_back();
    run_sweep(1, 8'h96, 1'b1, 1'b0, "b2b_a");
    run_sweep(2, 8'hEA, 1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    q_mode = 1'b0;
    sw_if.dwell = 8'd3;
    sw_if.expected = 8'hEA;
    sw_if.start = 1;
    step();
    sw_if.start = 0;
    repeat (7) step();
    rst_n = 0;
    step();
    rst_n = 1;
    tests_run++;
    if ({abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o, sw_if.pass, sw_if.truth, sw_if.mismatch} !== 23'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got abc=%b busy=%b done=%b valid=%b pass=%b truth=%h mismatch=%h required all zero",
               abc_now(), sw_if.busy, sw_if.done, sw_if.valid_o, sw_if.pass, sw_if.truth, sw_if.mismatch);
    end
    $display("[TB] reset_mid: outputs after mid-sweep reset checked");
    run_sweep(2, 8'hEA, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_abort();
    int dn;
    q_mode = 1'b0;
    sw_if.dwell = 8'd4;
    sw_if.expected = 8'hEA;
    sw_if.start = 1;
    step();
    sw_if.start = 0;
    repeat (9) step();
    sw_if.abort = 1;
    step();
    sw_if.abort = 0;
    tests_run++;
    if ({abc_now(), sw_if.busy, sw_if.valid_o, sw_if.done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL abort_ctrl: got abc=%b busy=%b valid=%b done=%b required all zero",
               abc_now(), sw_if.busy, sw_if.valid_o, sw_if.done);
    end
    tests_run++;
    if (sw_if.truth !== 8'h02) begin
      tests_failed++;
      $display("FAIL abort_truth: got %h required 02", sw_if.truth);
    end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (sw_if.done === 1'b1 || sw_if.busy === 1'b1) dn++;
      step();
    end
    tests_run++;
    if (dn !== 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got %0d cycles with done/busy required 0", dn);
    end
    sw_if.start = 1;
    sw_if.abort = 1;
    step();
    sw_if.start = 0;
    sw_if.abort = 0;
    tests_run++;
    if ({sw_if.busy, abc_now()} !== 4'b0) begin
      tests_failed++;
      $display("FAIL abort_vs_start: got busy=%b abc=%b required 0 000", sw_if.busy, abc_now());
    end
    step();
    tests_run++;
    if (sw_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_vs_start_late: got busy=%b required 0", sw_if.busy);
    end
    $display("[TB] abort: truth=%h busy=%b valid=%b", sw_if.truth, sw_if.busy, sw_if.valid_o);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_sweep(int'($urandom_range(0, 5)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell_zero();
    test_xor_mismatch();
    test_start_spam();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/abc_vector_sweeper.md
# abc_vector_sweeper

Upstream stimulus and capture stage for the three-input Q logic block. On a start request it drives A/B/C through all eight input vectors, 000 to 111, holding each vector for a programmable number of clock cycles. At the end of each hold it samples the block's Q output and builds an 8-bit measured truth table. It then compares that table against an expected table, which gives the lab an in-fabric exhaustive check of the Q logic instead of a simulation-only sweep.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel the sweep in progress; highest priority after reset.
- dwell  in  DWELL_W  hold cycles per vector; latched on accepted start; 0 is treated as 1.
- expected  in  8  reference truth table; bit k is the expected Q for vector k = {A,B,C}; latched on accepted start.
- q_in  in  1  Q from the logic block; synchronous to clk.
- a, b, c  out  1 each  vector bits, with a as the MSB; registered.
- busy  out  1  high while the sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- truth  out  8  measured table; bit k is Q sampled for vector k.
- mismatch  out  8  truth XOR latched expected; valid when valid_o=1.
- pass  out  1  valid_o AND (mismatch == 0).
- valid_o  out  1  results are valid; set with done, cleared on the next accepted start, on abort, or on reset.

## Operation
- FSM states:
  - IDLE to DRIVE on start.
  - DRIVE to DRIVE while the hold continues.
  - DRIVE to FINISH after the vector-7 sample.
  - FINISH to IDLE unconditionally.
  - Any state to IDLE on abort.
- Reset values:
  - State is IDLE.
  - a, b, c, busy, done, valid_o and pass are 0.
  - truth, mismatch and the latched expected table are 8'h00.
  - The vector counter is 0 and the dwell counter is 0.
- Accepted start (in IDLE):
  - Latch D = max(dwell,1) and the expected table.
  - Clear truth and valid_o.
  - Set vec = 0 and busy = 1.
- DRIVE:
  - {a,b,c} = vec, held for exactly D cycles.
  - On the clock edge that ends the D-th cycle, capture truth[vec] <= q_in.
  - Then increment vec and reload the dwell counter.
- After the sample for vec = 7, go to FINISH:
  - busy = 0, done = 1 for one cycle, valid_o = 1.
  - mismatch and pass are updated.
  - a, b, c return to 000.
- start while busy, or in FINISH, is ignored, with no effect on the sweep.
- abort, or rst_n low mid-sweep:
  - Return to IDLE.
  - a, b, c = 000, busy = 0, valid_o = 0; no done pulse.
  - Partial truth bits are retained for abort and cleared by reset.
- If abort and start are asserted in the same cycle in IDLE, abort wins and start is dropped.
- The dwell counter is DWELL_W bits and counts down from D-1 to 0. Vector wrap from 7 does not occur, because the sweep terminates.

## Timing
- start is sampled high at edge 0.
  - a, b, c = 000 and busy = 1 are visible in cycle 1.
  - Vector k is driven in cycles kD+1 through (k+1)D.
- truth[k] is captured at the edge that ends cycle (k+1)D. The Q logic therefore has D cycles of settle time per vector.
- done and valid_o rise in cycle 8D+1; done falls in cycle 8D+2.
- Total sweep is 8D+1 cycles from the start edge to the done cycle.
- A new start is accepted in cycle 8D+2 at the earliest, back-to-back.
- The outputs truth, mismatch and pass are stable from the done cycle until the next accepted start.

## Structure
- Package abc_sweep_pkg holds:
  - The state enum: IDLE, DRIVE, FINISH.
  - The constants NUM_VEC = 8 and VEC_W = 3.
- One sub-module, dwell_timer:
  - Loadable down-counter with ports load, value and expire.
  - Instantiated once for the per-vector hold.
- The top level contains the FSM, the vector counter and the result registers.

## Test plan
- Bench models Q = (A&B)|C, with dwell=4 and expected=8'hEA.
  - Required: truth=8'hEA, mismatch=8'h00, pass=1.
  - done is at cycle 33 after the start edge.
  - Each vector is held for exactly 4 cycles.
- dwell=0, same model.
  - Required: D=1, each vector is held for 1 cycle.
  - done is at cycle 9 and truth=8'hEA.
- Bench models Q = A^B^C, with expected=8'hEA.
  - Required: truth=8'h96, mismatch=8'h7C, pass=0, valid_o=1.
- Assert abort in cycle 10 of a dwell=4 sweep.
  - Required: the next cycle shows busy=0, abc=000, valid_o=0.
  - There is no done pulse, and truth bits 0 and 1 are retained.
- Pulse start repeatedly during a sweep.
  - Required: the timing is unchanged and exactly one done pulse occurs.
- Assert rst_n=0 mid-sweep for one cycle, then start a fresh sweep.
  - Required: all outputs show their reset values.
  - The new sweep completes normally with the correct truth table.
